// File: rtl/decoder.sv
`default_nettype none
// ============================================================================
// Module   : decoder
// Brief    : Single-cycle registered instruction decoder. Splits a 32-bit
//            instruction word into its format fields (D, W, T, I, fragment
//            marker, invalid). Fields not used by the decoded format are
//            driven to zero. No state is kept between instructions.
// Options  : DECODER_ILLEGAL_EN - adds a registered 'illegal' output that is
//            high for opcodes 110 and 111.
// Revision : 1.0 - initial release
// ============================================================================
module decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic [2:0]  op,
  output logic [1:0]  prefix,
  output logic [3:0]  funct,
  output logic [5:0]  nalloc,
  output logic        endF,
  output logic        immab,
  output logic [5:0]  immlo,
  output logic [25:0] immhi,
  output logic [9:0]  offset,
  output logic [5:0]  ta1,
  output logic [5:0]  ta2,
  output logic [5:0]  ta3,
  output logic [5:0]  ta4,
  output logic [1:0]  tt1,
  output logic [1:0]  tt2,
  output logic [1:0]  tt3,
  output logic [1:0]  tt4
`ifdef DECODER_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  // Opcode encodings
  localparam logic [2:0] c_OP_ALU   = 3'b000;
  localparam logic [2:0] c_OP_LOAD  = 3'b001;
  localparam logic [2:0] c_OP_STORE = 3'b010;
  localparam logic [2:0] c_OP_TPFX  = 3'b011;
  localparam logic [2:0] c_OP_IPFX  = 3'b100;
  localparam logic [2:0] c_OP_FRAG  = 3'b101;

  // Prefix encodings
  localparam logic [1:0] c_PFX_NONE    = 2'b00;
  localparam logic [1:0] c_PFX_T       = 2'b01;
  localparam logic [1:0] c_PFX_I       = 2'b10;
  localparam logic [1:0] c_PFX_INVALID = 2'b11;

  // Next-cycle field values (combinational decode of the current word)
  logic [2:0]  w_op;
  logic [1:0]  w_prefix;
  logic [3:0]  w_funct;
  logic [5:0]  w_nalloc;
  logic        w_endF;
  logic        w_immab;
  logic [5:0]  w_immlo;
  logic [25:0] w_immhi;
  logic [9:0]  w_offset;
  logic [5:0]  w_ta1, w_ta2, w_ta3, w_ta4;
  logic [1:0]  w_tt1, w_tt2, w_tt3, w_tt4;

  // Registered outputs
  logic [2:0]  r_op;
  logic [1:0]  r_prefix;
  logic [3:0]  r_funct;
  logic [5:0]  r_nalloc;
  logic        r_endF;
  logic        r_immab;
  logic [5:0]  r_immlo;
  logic [25:0] r_immhi;
  logic [9:0]  r_offset;
  logic [5:0]  r_ta1, r_ta2, r_ta3, r_ta4;
  logic [1:0]  r_tt1, r_tt2, r_tt3, r_tt4;

  // Format decode: every field defaults to zero, then the opcode selects
  // which slices of the word are routed to which fields.
  always_comb begin
    w_op     = instruction[31:29];
    w_prefix = c_PFX_NONE;
    w_funct  = '0;
    w_nalloc = '0;
    w_endF   = 1'b0;
    w_immab  = 1'b0;
    w_immlo  = '0;
    w_immhi  = '0;
    w_offset = '0;
    w_ta1    = '0;
    w_ta2    = '0;
    w_ta3    = '0;
    w_ta4    = '0;
    w_tt1    = '0;
    w_tt2    = '0;
    w_tt3    = '0;
    w_tt4    = '0;

    case (w_op)
      c_OP_ALU, c_OP_LOAD: begin
        // Format D: ta1 shares its bits with immlo
        w_funct = instruction[28:25];
        w_immab = instruction[24];
        w_immlo = instruction[23:18];
        w_ta1   = instruction[23:18];
        w_tt1   = instruction[17:16];
        w_tt2   = instruction[15:14];
        w_ta2   = instruction[13:8];
        w_tt3   = instruction[7:6];
        w_ta3   = instruction[5:0];
      end
      c_OP_STORE: begin
        // Format W: bits [17:10] carry nothing
        w_funct  = instruction[28:25];
        w_immab  = instruction[24];
        w_immlo  = instruction[23:18];
        w_ta1    = instruction[23:18];
        w_offset = instruction[9:0];
      end
      c_OP_TPFX: begin
        // Format T: extends targets 3 and 4 of the following instruction
        w_prefix = c_PFX_T;
        w_tt3    = instruction[15:14];
        w_ta3    = instruction[13:8];
        w_tt4    = instruction[7:6];
        w_ta4    = instruction[5:0];
      end
      c_OP_IPFX: begin
        // Format I: supplies the high immediate bits
        w_prefix = c_PFX_I;
        w_immhi  = instruction[25:0];
      end
      c_OP_FRAG: begin
        // Fragment marker: end/start flag plus allocation count
        w_endF   = instruction[28];
        w_nalloc = instruction[5:0];
      end
      default: begin
        // Opcodes 110/111: flag invalid, all payload fields stay zero
        w_prefix = c_PFX_INVALID;
      end
    endcase
  end

  // Output register: reset clears everything, otherwise capture the decode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_prefix <= '0;
      r_funct  <= '0;
      r_nalloc <= '0;
      r_endF   <= 1'b0;
      r_immab  <= 1'b0;
      r_immlo  <= '0;
      r_immhi  <= '0;
      r_offset <= '0;
      r_ta1    <= '0;
      r_ta2    <= '0;
      r_ta3    <= '0;
      r_ta4    <= '0;
      r_tt1    <= '0;
      r_tt2    <= '0;
      r_tt3    <= '0;
      r_tt4    <= '0;
    end else begin
      r_op     <= w_op;
      r_prefix <= w_prefix;
      r_funct  <= w_funct;
      r_nalloc <= w_nalloc;
      r_endF   <= w_endF;
      r_immab  <= w_immab;
      r_immlo  <= w_immlo;
      r_immhi  <= w_immhi;
      r_offset <= w_offset;
      r_ta1    <= w_ta1;
      r_ta2    <= w_ta2;
      r_ta3    <= w_ta3;
      r_ta4    <= w_ta4;
      r_tt1    <= w_tt1;
      r_tt2    <= w_tt2;
      r_tt3    <= w_tt3;
      r_tt4    <= w_tt4;
    end
  end

  assign op     = r_op;
  assign prefix = r_prefix;
  assign funct  = r_funct;
  assign nalloc = r_nalloc;
  assign endF   = r_endF;
  assign immab  = r_immab;
  assign immlo  = r_immlo;
  assign immhi  = r_immhi;
  assign offset = r_offset;
  assign ta1    = r_ta1;
  assign ta2    = r_ta2;
  assign ta3    = r_ta3;
  assign ta4    = r_ta4;
  assign tt1    = r_tt1;
  assign tt2    = r_tt2;
  assign tt3    = r_tt3;
  assign tt4    = r_tt4;

`ifdef DECODER_ILLEGAL_EN
  logic w_illegal;
  logic r_illegal;

  assign w_illegal = w_op[2] & w_op[1];

  // Illegal-opcode flag, registered alongside the other fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_illegal;
    end
  end

  assign illegal = r_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder
// Brief    : Self-checking bench for decoder: directed vectors plus random
//            instruction words compared against a field-extraction model.
//            Define DECODER_ILLEGAL_EN to also check the illegal output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [2:0]  op;
  logic [1:0]  prefix;
  logic [3:0]  funct;
  logic [5:0]  nalloc;
  logic        endF;
  logic        immab;
  logic [5:0]  immlo;
  logic [25:0] immhi;
  logic [9:0]  offset;
  logic [5:0]  ta1, ta2, ta3, ta4;
  logic [1:0]  tt1, tt2, tt3, tt4;
`ifdef DECODER_ILLEGAL_EN
  logic        illegal;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned op, prefix, funct, nalloc, endF, immab, immlo, immhi, offset;
    int unsigned ta1, ta2, ta3, ta4, tt1, tt2, tt3, tt4, illegal;
  } fields_t;

  fields_t exp_f;

  decoder dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .op          (op),
    .prefix      (prefix),
    .funct       (funct),
    .nalloc      (nalloc),
    .endF        (endF),
    .immab       (immab),
    .immlo       (immlo),
    .immhi       (immhi),
    .offset      (offset),
    .ta1         (ta1),
    .ta2         (ta2),
    .ta3         (ta3),
    .ta4         (ta4),
    .tt1         (tt1),
    .tt2         (tt2),
    .tt3         (tt3),
    .tt4         (tt4)
`ifdef DECODER_ILLEGAL_EN
    ,
    .illegal     (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input int unsigned obs, input int unsigned expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: pick the instruction apart by shifting and masking,
  // according to the format each opcode selects.
  function automatic fields_t model(input int unsigned w, input bit r);
    fields_t f;
    int unsigned o;
    f = '{default: 0};
    if (r) return f;
    o = w >> 29;
    f.op = o;
    if (o <= 1) begin
      f.funct = (w >> 25) % 16;
      f.immab = (w >> 24) % 2;
      f.immlo = (w >> 18) % 64;
      f.ta1   = f.immlo;
      f.tt1   = (w >> 16) % 4;
      f.tt2   = (w >> 14) % 4;
      f.ta2   = (w >> 8) % 64;
      f.tt3   = (w >> 6) % 4;
      f.ta3   = w % 64;
    end else if (o == 2) begin
      f.funct  = (w >> 25) % 16;
      f.immab  = (w >> 24) % 2;
      f.immlo  = (w >> 18) % 64;
      f.ta1    = f.immlo;
      f.offset = w % 1024;
    end else if (o == 3) begin
      f.prefix = 1;
      f.tt3 = (w >> 14) % 4;
      f.ta3 = (w >> 8) % 64;
      f.tt4 = (w >> 6) % 4;
      f.ta4 = w % 64;
    end else if (o == 4) begin
      f.prefix = 2;
      f.immhi  = w % (1 << 26);
    end else if (o == 5) begin
      f.endF   = (w >> 28) % 2;
      f.nalloc = w % 64;
    end else begin
      f.prefix  = 3;
      f.illegal = 1;
    end
    return f;
  endfunction

  task automatic check_all(input fields_t e);
    chk("op", op, e.op);         chk("prefix", prefix, e.prefix);
    chk("funct", funct, e.funct); chk("nalloc", nalloc, e.nalloc);
    chk("endF", endF, e.endF);    chk("immab", immab, e.immab);
    chk("immlo", immlo, e.immlo); chk("immhi", immhi, e.immhi);
    chk("offset", offset, e.offset);
    chk("ta1", ta1, e.ta1); chk("ta2", ta2, e.ta2);
    chk("ta3", ta3, e.ta3); chk("ta4", ta4, e.ta4);
    chk("tt1", tt1, e.tt1); chk("tt2", tt2, e.tt2);
    chk("tt3", tt3, e.tt3); chk("tt4", tt4, e.tt4);
`ifdef DECODER_ILLEGAL_EN
    chk("illegal", illegal, e.illegal);
`endif
  endtask

  // Apply one word for one edge, then check the registered result
  task automatic step(input logic [31:0] w, input bit r);
    @(negedge clk);
    instruction = w;
    rst = r;
    @(posedge clk);
    #1;
    exp_f = model(w, r);
    check_all(exp_f);
  endtask

  initial begin
    rst = 1'b1;
    instruction = 32'hFFFF_FFFF;
    step(32'hFFFF_FFFF, 1'b1);
    check_all('{default: 0});

    // Format D
    step(32'b001_0101_1_110011_00_10_010101_11_000111, 1'b0);
    chk("d_funct", funct, 4'b0101); chk("d_ta1", ta1, 6'h33);
    chk("d_ta2", ta2, 6'h15);       chk("d_ta3", ta3, 6'h07);
    chk("d_tt2", tt2, 2'b10);       chk("d_tt3", tt3, 2'b11);

    // Format W
    step(32'b010_0011_0_010101_00000000_1011001110, 1'b0);
    chk("w_offset", offset, 10'h2CE); chk("w_immlo", immlo, 6'h15);

    // Format T
    step(32'b011_0000000000000_10_101010_11_111100, 1'b0);
    chk("t_prefix", prefix, 2'b01); chk("t_ta3", ta3, 6'h2A);
    chk("t_ta4", ta4, 6'h3C);

    // Format I, then fragment marker
    step(32'b100_000_10101010101010101010101010, 1'b0);
    chk("i_immhi", immhi, 26'h2AAAAAA); chk("i_prefix", prefix, 2'b10);
    step(32'b101_0_0000000000000000000000_110011, 1'b0);
    chk("f_nalloc", nalloc, 6'h33); chk("f_endF", endF, 1'b0);

    // Invalid word, then a single reset edge
    step(32'hFFFF_FFFF, 1'b0);
    chk("inv_op", op, 3'b111); chk("inv_prefix", prefix, 2'b11);
`ifdef DECODER_ILLEGAL_EN
    chk("inv_illegal", illegal, 1'b1);
`endif
    step(32'hFFFF_FFFF, 1'b1);
    check_all('{default: 0});

    // Input changes between edges must not reach the outputs early
    step(32'b011_0000000000000_10_101010_11_111100, 1'b0);
    instruction = 32'b100_000_10101010101010101010101010;
    #2;
    check_all(exp_f);
    step(32'h0123_4567, 1'b0);

    // Random words with occasional reset
    for (int i = 0; i < 1500; i++) begin
      step($urandom, ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
